meta_egress_buffer: RTL
=======================

META_EGRESS_BUFFER -- requirements
Module: meta_egress_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, >= 2.
REQ-002 SHALL have parameter CNT_W, default 32, statistics counter width.
REQ-003 SHALL have port aclk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port areset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port meta_in, input, parsed_metadata_t, metadata from the packet parser top.
REQ-006 SHALL have port meta_in_valid, input, 1, one-cycle pulse qualifying meta_in; there is no backpressure toward the parser.
REQ-007 SHALL have port m_meta, output, parsed_metadata_t, head-of-FIFO metadata.
REQ-008 SHALL have port m_meta_valid, output, 1, head entry present.
REQ-009 SHALL have port m_meta_ready, input, 1, downstream accepts head.
REQ-010 SHALL have port clear_stats, input, 1, synchronous clear of the statistics.
REQ-011 SHALL have port fifo_count, output, $clog2(DEPTH+1), entries held.
REQ-012 SHALL have ports ipv4_count, ipv6_count and drop_count, output, CNT_W each, statistics.
REQ-013 SHALL have port overflow, output, 1, sticky flag set by any drop.

Function
REQ-014 SHALL define pop = m_meta_valid && m_meta_ready; a pop removes the head at the clock edge.
REQ-015 SHALL define push = meta_in_valid && (fifo_count < DEPTH || pop); a full FIFO with a simultaneous pop accepts the write.
REQ-016 SHALL define drop = meta_in_valid && !push; the dropped entry is discarded and FIFO contents are unchanged.
REQ-017 SHALL update fifo_count each cycle as +1 on push only, -1 on pop only, and unchanged on both or neither.
REQ-018 SHALL wrap the write and read pointers modulo DEPTH.
REQ-019 SHALL present data first-word-fall-through: an entry pushed at edge N drives m_meta and m_meta_valid=1 from cycle N+1 when the FIFO was empty; there is no combinational path from meta_in to m_meta.
REQ-020 SHALL drive m_meta_valid = (fifo_count != 0).
REQ-021 SHALL drive m_meta = '0 while empty.
REQ-022 SHALL hold m_meta and m_meta_valid stable while m_meta_valid=1 and m_meta_ready=0.
REQ-023 SHALL preserve arrival order; no reordering or duplication.
REQ-024 SHALL increment ipv4_count on a push with meta_in.is_ipv4=1.
REQ-025 SHALL increment ipv6_count on a push with meta_in.is_ipv6=1 and is_ipv4=0.
REQ-026 SHALL NOT increment either protocol counter on a push with both flags 0.
REQ-027 SHALL increment drop_count on each drop and set overflow to 1.
REQ-028 SHALL saturate all counters at all-ones; there is no wrap.
REQ-029 SHALL on clear_stats=1 zero ipv4_count, ipv6_count, drop_count and overflow; clear wins over a same-cycle increment, and FIFO contents and fifo_count are unaffected.
REQ-030 SHALL ignore m_meta_ready while empty.

Reset
REQ-031 SHALL on areset=1, immediately and independently of aclk, force pointers and fifo_count to 0, m_meta_valid=0, m_meta='0, all counters 0 and overflow=0.
REQ-032 SHALL discard buffered entries when reset is asserted mid-operation.
REQ-033 SHALL accept the first push on the first rising edge after areset deasserts.

Verification
REQ-034 Scenario: one IPv4 pulse with m_meta_ready=0 -> next cycle m_meta_valid=1, m_meta equals the input, fifo_count=1, ipv4_count=1; ready=1 for one cycle -> fifo_count=0, m_meta='0.
REQ-035 Scenario: DEPTH=4, ready=0, 6 pulses (A..F) -> fifo_count=4, drop_count=2, overflow=1; drain -> outputs A,B,C,D in order.
REQ-036 Scenario: FIFO full, ready=1 and a pulse in the same cycle -> push accepted, fifo_count stays 4, drop_count unchanged.
REQ-037 Scenario: 3 IPv4, 2 IPv6 and 1 with both flags 0 -> ipv4_count=3, ipv6_count=2, fifo_count=6 capped by DEPTH (with DEPTH=8: fifo_count=6).
REQ-038 Scenario: clear_stats coincident with a drop -> drop_count=0, overflow=0 next cycle, fifo_count unchanged.
REQ-039 Scenario: areset pulse with 3 entries buffered -> all outputs 0 asynchronously; a push after release -> fifo_count=1 with the new entry at the head.

Source files
------------

// File: rtl/meta_egress_buffer.sv
// meta_egress_buffer: first-word-fall-through FIFO that decouples parsed packet
// metadata from the downstream consumer, with protocol and drop statistics.
//
// Ports:
//   aclk, areset       - clock (rising edge) and asynchronous active-high reset
//   meta_in(_valid)    - metadata from the parser; a pulse, no backpressure
//   m_meta(_valid)     - head-of-FIFO metadata ('0 while empty)
//   m_meta_ready       - downstream accepts the head this cycle
//   clear_stats        - synchronous clear of counters and overflow flag
//   fifo_count         - number of entries held
//   ipv4/ipv6/drop_count, overflow - saturating statistics, sticky drop flag

package meta_egress_pkg;
    typedef struct packed {
        logic        is_ipv4;
        logic        is_ipv6;
        logic        is_tcp;
        logic        is_udp;
        logic [7:0]  ip_proto;
        logic [15:0] l4_dst_port;
        logic [11:0] pkt_len;
    } parsed_metadata_t;
endpackage

module meta_egress_buffer
    import meta_egress_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  parsed_metadata_t           meta_in,
    input  logic                       meta_in_valid,
    output parsed_metadata_t           m_meta,
    output logic                       m_meta_valid,
    input  logic                       m_meta_ready,
    input  logic                       clear_stats,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [CNT_W-1:0]           ipv4_count,
    output logic [CNT_W-1:0]           ipv6_count,
    output logic [CNT_W-1:0]           drop_count,
    output logic                       overflow
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = $clog2(DEPTH+1);
    localparam logic [CountW-1:0] FullCount = CountW'(DEPTH);

    parsed_metadata_t  mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic [CNT_W-1:0]  ipv4_q, ipv4_d;
    logic [CNT_W-1:0]  ipv6_q, ipv6_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              ovf_q, ovf_d;

    logic push, pop, drop;

    always_comb begin
        // count_q never exceeds DEPTH, so "not full" is "count < DEPTH".
        pop  = (count_q != '0) && m_meta_ready;
        push = meta_in_valid && ((count_q != FullCount) || pop);
        drop = meta_in_valid && !push;

        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CountW'(1);
            2'b01:   count_d = count_q - CountW'(1);
            default: count_d = count_q;
        endcase

        ipv4_d = ipv4_q;
        ipv6_d = ipv6_q;
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (clear_stats) begin
            // Clear takes priority over any increment in the same cycle.
            ipv4_d = '0;
            ipv6_d = '0;
            drop_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (push && meta_in.is_ipv4) begin
                if (ipv4_q != '1) ipv4_d = ipv4_q + CNT_W'(1);
            end else if (push && meta_in.is_ipv6) begin
                if (ipv6_q != '1) ipv6_d = ipv6_q + CNT_W'(1);
            end
            if (drop) begin
                if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ipv4_q   <= '0;
            ipv6_q   <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ipv4_q   <= ipv4_d;
            ipv6_q   <= ipv6_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once count_q is 0.
    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_ptr_q] <= meta_in;
    end

    always_comb begin
        m_meta_valid = (count_q != '0);
        m_meta       = m_meta_valid ? mem_q[rd_ptr_q] : '0;
        fifo_count   = count_q;
        ipv4_count   = ipv4_q;
        ipv6_count   = ipv6_q;
        drop_count   = drop_q;
        overflow     = ovf_q;
    end

endmodule
